instruction_decoder: RTL

INSTRUCTION_DECODER -- requirements
Module: instruction_decoder

---
 rtl/instruction_decoder.sv | 133 +++++++++++++
 1 files changed

// File: rtl/instruction_decoder.sv
// Byte-serial instruction decoder: collects an opcode plus 0-2 operand bytes,
// then holds the decoded instruction on its outputs until the consumer acks it.
module instruction_decoder #(
  parameter int byte_width  = 8,
  parameter int width_in    = 1 * byte_width,
  parameter int count_width = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_for_decoder,
  input  logic [width_in-1:0]    data_for_decoder,
  output logic                   ready_from_decoder,
  input  logic                   instr_ack,
  output logic                   instr_valid,
  output logic [byte_width-1:0]  opcode,
  output logic [byte_width-1:0]  operand_a,
  output logic [byte_width-1:0]  operand_b,
  output logic [1:0]             operand_count,
  output logic                   illegal_opcode,
  output logic [count_width-1:0] instr_count
);

  typedef enum logic [1:0] {
    WAIT_OPCODE = 2'd0,
    WAIT_OP_A   = 2'd1,
    WAIT_OP_B   = 2'd2,
    ISSUE       = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic                   ready_q, ready_d;
  logic                   valid_q, valid_d;
  logic [byte_width-1:0]  opcode_q, opcode_d;
  logic [byte_width-1:0]  operand_a_q, operand_a_d;
  logic [byte_width-1:0]  operand_b_q, operand_b_d;
  logic [1:0]             operand_count_q, operand_count_d;
  logic                   illegal_q, illegal_d;
  logic [count_width-1:0] instr_count_q, instr_count_d;

  logic [byte_width-1:0]  byte_in;
  logic [1:0]             n_in;
  logic [1:0]             n_held;
  logic                   accept;

  assign byte_in = data_for_decoder[byte_width-1:0];
  assign n_in    = byte_in[byte_width-1 -: 2];
  assign n_held  = opcode_q[byte_width-1 -: 2];
  // ready_q is a flop, so a strobe can never reach ready through logic.
  assign accept  = start_for_decoder & ready_q;

  always_comb begin
    state_d         = state_q;
    opcode_d        = opcode_q;
    operand_a_d     = operand_a_q;
    operand_b_d     = operand_b_q;
    operand_count_d = operand_count_q;
    illegal_d       = illegal_q;
    instr_count_d   = instr_count_q;

    case (state_q)
      WAIT_OPCODE: begin
        if (accept) begin
          opcode_d        = byte_in;
          operand_a_d     = '0;
          operand_b_d     = '0;
          operand_count_d = 2'd0;
          illegal_d       = (n_in == 2'd3);
          if (n_in == 2'd0 || n_in == 2'd3) state_d = ISSUE;
          else                              state_d = WAIT_OP_A;
        end
      end
      WAIT_OP_A: begin
        if (accept) begin
          operand_a_d     = byte_in;
          operand_count_d = 2'd1;
          state_d         = (n_held == 2'd2) ? WAIT_OP_B : ISSUE;
        end
      end
      WAIT_OP_B: begin
        if (accept) begin
          operand_b_d     = byte_in;
          operand_count_d = 2'd2;
          state_d         = ISSUE;
        end
      end
      ISSUE: begin
        // Counter wraps silently at its full width.
        if (instr_ack) begin
          state_d       = WAIT_OPCODE;
          instr_count_d = instr_count_q + count_width'(1);
        end
      end
      default: state_d = WAIT_OPCODE;
    endcase

    valid_d = (state_d == ISSUE);
    ready_d = (state_d != ISSUE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= WAIT_OPCODE;
      ready_q         <= 1'b1;
      valid_q         <= 1'b0;
      opcode_q        <= '0;
      operand_a_q     <= '0;
      operand_b_q     <= '0;
      operand_count_q <= 2'd0;
      illegal_q       <= 1'b0;
      instr_count_q   <= '0;
    end else begin
      state_q         <= state_d;
      ready_q         <= ready_d;
      valid_q         <= valid_d;
      opcode_q        <= opcode_d;
      operand_a_q     <= operand_a_d;
      operand_b_q     <= operand_b_d;
      operand_count_q <= operand_count_d;
      illegal_q       <= illegal_d;
      instr_count_q   <= instr_count_d;
    end
  end

  assign ready_from_decoder = ready_q;
  assign instr_valid        = valid_q;
  assign opcode             = opcode_q;
  assign operand_a          = operand_a_q;
  assign operand_b          = operand_b_q;
  assign operand_count      = operand_count_q;
  assign illegal_opcode     = illegal_q;
  assign instr_count        = instr_count_q;

endmodule
